// File: rtl/byte_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : byte_bus_arbiter_if
//  Description : Bundles the fetch requester, the data requester and the
//                byte-wide memory port of byte_bus_arbiter.
//                The slave modport is the arbiter's view. The master modport
//                is the view of the core and memory that surround it.
//  Revision    : 1.0  initial release
// ============================================================================
interface byte_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  // Data requester
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  // Byte-wide memory port
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wdata;
  logic [7:0]        m_rdata;
  // Status
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/byte_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : byte_bus_arbiter
//  Description : Round-robin arbiter between an instruction-fetch port and a
//                data port. It serialises each granted access into 1, 2 or 4
//                byte cycles on a single byte-wide memory with 1-cycle read
//                latency. The fetch or load result is returned with a
//                one-cycle ack pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  byte_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_LAST = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic [1:0] c_WORD_LAST_IDX = 2'd3;

  state_t            r_state;
  logic [1:0]        r_cnt;       // byte currently on the memory bus
  logic [1:0]        r_last_idx;  // N-1 for the granted transfer
  logic              r_gnt_d;     // current grant belongs to the data port
  logic              r_last_d;    // most recent grant went to the data port
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [31:0]       r_result;

  logic              r_i_ack;
  logic [31:0]       r_i_rdata;
  logic              r_d_ack;
  logic [31:0]       r_d_rdata;
  logic              r_m_en;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [7:0]        r_m_wdata;
  logic              r_busy;

  logic              w_req_any;
  logic              w_grant_d;
  logic [1:0]        w_d_last_idx;
  logic [1:0]        w_cnt_nxt;
  logic [1:0]        w_prev_cnt;
  logic [31:0]       w_result_fin;

  // The data port wins a contention unless it was the previous winner.
  assign w_req_any  = bus.i_req | bus.d_req;
  assign w_grant_d  = bus.d_req & (~bus.i_req | ~r_last_d);
  assign w_cnt_nxt  = r_cnt + 2'd1;
  assign w_prev_cnt = r_cnt - 2'd1;

  // Size code 11 is handled as a full word.
  always_comb begin
    w_d_last_idx = c_WORD_LAST_IDX;
    case (bus.d_size)
      2'b00:   w_d_last_idx = 2'd0;
      2'b01:   w_d_last_idx = 2'd1;
      default: w_d_last_idx = c_WORD_LAST_IDX;
    endcase
  end

  // Result with the final read byte merged in. It is used in LAST, where that
  // byte is still on m_rdata and the ack data must be registered on this edge.
  always_comb begin
    w_result_fin = r_result;
    if (!r_we) begin
      w_result_fin[{r_cnt, 3'b000} +: 8] = bus.m_rdata;
    end
  end

  // Arbitration and transfer sequencing, with every output registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_last_idx <= 2'd0;
      r_gnt_d    <= 1'b0;
      r_last_d   <= 1'b0;
      r_we       <= 1'b0;
      r_base     <= '0;
      r_wdata    <= 32'd0;
      r_result   <= 32'd0;
      r_i_ack    <= 1'b0;
      r_i_rdata  <= 32'd0;
      r_d_ack    <= 1'b0;
      r_d_rdata  <= 32'd0;
      r_m_en     <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= 8'd0;
      r_busy     <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_state  <= S_XFER;
            r_busy   <= 1'b1;
            r_cnt    <= 2'd0;
            r_result <= 32'd0;
            r_gnt_d  <= w_grant_d;
            r_last_d <= w_grant_d;
            r_m_en   <= 1'b1;
            if (w_grant_d) begin
              r_base     <= bus.d_addr;
              r_we       <= bus.d_we;
              r_wdata    <= bus.d_wdata;
              r_last_idx <= w_d_last_idx;
              r_m_we     <= bus.d_we;
              r_m_addr   <= bus.d_addr;
              r_m_wdata  <= bus.d_wdata[7:0];
            end else begin
              r_base     <= bus.i_addr;
              r_we       <= 1'b0;
              r_wdata    <= 32'd0;
              r_last_idx <= c_WORD_LAST_IDX;
              r_m_we     <= 1'b0;
              r_m_addr   <= bus.i_addr;
              r_m_wdata  <= 8'd0;
            end
          end
        end

        S_XFER: begin
          // The byte strobed in the previous cycle is on m_rdata now.
          if (!r_we && (r_cnt != 2'd0)) begin
            r_result[{w_prev_cnt, 3'b000} +: 8] <= bus.m_rdata;
          end
          if (r_cnt == r_last_idx) begin
            r_state   <= S_LAST;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= 8'd0;
          end else begin
            r_cnt     <= w_cnt_nxt;
            r_m_addr  <= r_base + {{(ADDR_W-2){1'b0}}, w_cnt_nxt};
            r_m_wdata <= r_wdata[{w_cnt_nxt, 3'b000} +: 8];
          end
        end

        S_LAST: begin
          r_state  <= S_ACK;
          r_result <= w_result_fin;
          if (r_gnt_d) begin
            r_d_ack   <= 1'b1;
            r_d_rdata <= w_result_fin;
          end else begin
            r_i_ack   <= 1'b1;
            r_i_rdata <= w_result_fin;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_ack   = r_i_ack;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_ack   = r_d_ack;
  assign bus.d_rdata = r_d_rdata;
  assign bus.m_en    = r_m_en;
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: doc/byte_bus_arbiter.md
BYTE_BUS_ARBITER -- requirements
Module: byte_bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of requester and memory ports.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_req  in  1  instruction-fetch request; held high until i_ack.
REQ-005 i_addr  in  ADDR_W  fetch byte address; always a 4-byte read.
REQ-006 i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle.
REQ-007 i_rdata  out  32  fetched word, little-endian.
REQ-008 d_req  in  1  data request; held high until d_ack.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_size  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
REQ-011 d_addr  in  ADDR_W  data byte address; no alignment requirement.
REQ-012 d_wdata  in  32  store data; byte k taken from bits [8k+7:8k].
REQ-013 d_ack  out  1  one-cycle completion pulse.
REQ-014 d_rdata  out  32  load data, zero-extended; sign extension is the core's job.
REQ-015 m_en  out  1  memory byte-access strobe.
REQ-016 m_we  out  1  memory write enable; qualified by m_en.
REQ-017 m_addr  out  ADDR_W  memory byte address.
REQ-018 m_wdata  out  8  memory write byte.
REQ-019 m_rdata  in  8  memory read byte; valid in the cycle after a read strobe (latency 1).
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, XFER, LAST, ACK. All outputs are registered.
REQ-022 IDLE: if any request is high at a rising edge, grant one requester, latch its address, size, direction and write data, clear the byte counter, and go to XFER.
REQ-023 Arbitration is round-robin. When both requests are high, grant the requester not granted last. A single active requester is granted immediately.
REQ-024 Transfer byte count N: 4 for fetch; 1, 2 or 4 for data, per d_size.
REQ-025 XFER lasts N cycles. In byte cycle k: m_en=1, m_we=latched we, m_addr=base+k mod 2^ADDR_W, m_wdata=wdata byte k.
REQ-026 Read capture: the m_rdata byte present in the cycle after byte k's strobe is stored into result bits [8k+7:8k]. Unread upper bytes are 0.
REQ-027 After byte N-1, go to LAST for 1 cycle with m_en=0. The final read byte is captured here; stores pass through LAST unchanged.
REQ-028 ACK lasts 1 cycle: the granted requester's ack=1 with rdata valid (stores: rdata=0); the other ack stays 0. Next state is IDLE.
REQ-029 Latency: with req first high in IDLE cycle 0, ack is in cycle N+2. Word fetch → cycle 6; byte load/store → cycle 3.
REQ-030 Minimum spacing between consecutive grants is one IDLE cycle; no grant is made from ACK.
REQ-031 The granted request is not re-sampled during a transfer. If the requester drops req mid-transfer, the transfer still completes and the ack still pulses.
REQ-032 Inputs captured at grant are frozen. Changes to addr, we, size or wdata after grant have no effect.
REQ-033 m_en, m_we, m_addr and m_wdata are 0 in IDLE, LAST and ACK.
REQ-034 i_rdata and d_rdata hold their last value except at ACK update; they reset to 0.
REQ-035 Address wrap: base 0xFFFFFFFE word access issues addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.

Reset
REQ-036 While rst_n=0, the block is held in reset. State=IDLE, byte counter=0, last-grant=instruction (so data wins the first contention), and every output is 0.
REQ-037 Reset asserted mid-transfer abandons the transfer immediately: m_en drops without waiting for a clock and no ack is issued. After release the block is in IDLE.
REQ-038 The first grant may occur at the first rising edge after rst_n deasserts.

Verification
REQ-039 Fetch, i_addr=0x10, memory bytes 13,37,BE,EF at 0x10..0x13: m_addr 10,11,12,13 in cycles 1-4; i_ack in cycle 6; i_rdata=0xEFBE3713.
REQ-040 Store byte, d_addr=0x7, d_wdata=0x000000A5: a single m_en/m_we cycle with m_addr=7, m_wdata=A5; d_ack in cycle 3.
REQ-041 Load half, d_addr=0x3, mem[3]=0x80, mem[4]=0xFF: d_rdata=0x0000FF80 (no sign extension); d_ack in cycle 4.
REQ-042 i_req and d_req both high from reset release: data granted first. Fetch is granted at the next IDLE. Repeat contention alternates grants.
REQ-043 rst_n pulsed low during byte 2 of a fetch: m_en=0 asynchronously and no i_ack. With i_req still high after release, the fetch restarts from byte 0.
REQ-044 Word load at 0xFFFFFFFE: address sequence wraps to 0x00000000/0x00000001 per REQ-035.
